// File: rtl/wb_commit_stage.sv
// Write-back / commit stage.
// Registers one retiring instruction per cycle from MEM, issues the register
// file write, and produces the difftest qualifiers (commit pulse, skip flag,
// interrupt number). It counts retired instructions and freezes the pipeline
// once the simulation-trap instruction has retired.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   i_mem_valid         MEM stage presents an instruction
//   o_mem_ready         stage can accept (RUN state)
//   i_pc/i_inst         PC and instruction word of the presented slot
//   i_rd/i_rd_wen/i_rd_wdata   destination write request
//   i_mem_access/i_mem_addr    load/store flag and effective address
//   i_intrNo            nonzero: interrupt taken on this slot
//   o_rd/o_rd_wen/o_rd_wdata   register file write port
//   o_pc/o_inst         registered PC and instruction
//   o_cmtvalid          one-cycle pulse per retired instruction
//   o_skipcmt           difftest must skip comparison for this commit
//   o_intrNo            registered interrupt number (one cycle)
//   o_halted            trap retired, pipeline frozen
//   o_instret           retired-instruction count
module wb_commit_stage #(
    parameter logic [63:0] MMIO_TOP    = 64'h0000_0000_8000_0000,
    parameter logic [6:0]  TRAP_OPCODE = 7'h6b
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_valid,
    output logic        o_mem_ready,
    input  logic [63:0] i_pc,
    input  logic [31:0] i_inst,
    input  logic [4:0]  i_rd,
    input  logic        i_rd_wen,
    input  logic [63:0] i_rd_wdata,
    input  logic        i_mem_access,
    input  logic [63:0] i_mem_addr,
    input  logic [31:0] i_intrNo,
    output logic [4:0]  o_rd,
    output logic        o_rd_wen,
    output logic [63:0] o_rd_wdata,
    output logic [63:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_cmtvalid,
    output logic        o_skipcmt,
    output logic [31:0] o_intrNo,
    output logic        o_halted,
    output logic [63:0] o_instret
);

    localparam int unsigned XLEN = 64;
    localparam logic [6:0]  SYSTEM_OPCODE = 7'h73;
    localparam logic [11:0] CSR_MCYCLE = 12'hB00;
    localparam logic [11:0] CSR_CYCLE  = 12'hC00;
    localparam logic [11:0] CSR_MIP    = 12'h344;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;
    logic   normal;
    logic   mmio_hit;
    logic   csr_hit;
    logic   skip;

    // Next-state and slot classification.
    always_comb begin
        state_next = state;
        accept     = i_mem_valid && (state == RUN);
        normal     = accept && (i_intrNo == 32'd0);
        mmio_hit   = i_mem_access && (i_mem_addr < MMIO_TOP);
        // Counter/interrupt-pending CSR reads are nondeterministic against the reference model.
        csr_hit    = (i_inst[6:0] == SYSTEM_OPCODE) && (i_inst[14:12] != 3'd0) &&
                     ((i_inst[31:20] == CSR_MCYCLE) || (i_inst[31:20] == CSR_CYCLE) ||
                      (i_inst[31:20] == CSR_MIP));
        skip       = normal && (mmio_hit || csr_hit);
        // Halt lands on the same edge that registers the trap's commit.
        if (normal && (i_inst[6:0] == TRAP_OPCODE)) begin
            state_next = HALT;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            o_rd       <= 5'd0;
            o_rd_wen   <= 1'b0;
            o_rd_wdata <= 64'd0;
            o_pc       <= 64'd0;
            o_inst     <= 32'd0;
            o_cmtvalid <= 1'b0;
            o_skipcmt  <= 1'b0;
            o_intrNo   <= 32'd0;
            o_instret  <= 64'd0;
        end else begin
            state      <= state_next;
            o_cmtvalid <= normal;
            o_rd_wen   <= normal && i_rd_wen && (i_rd != 5'd0);
            o_skipcmt  <= skip;
            o_intrNo   <= accept ? i_intrNo : 32'd0;
            if (accept) begin
                o_pc       <= i_pc;
                o_inst     <= i_inst;
                o_rd       <= i_rd;
                o_rd_wdata <= i_rd_wdata;
            end
            if (normal) begin
                o_instret <= o_instret + XLEN'(1);
            end
        end
    end

    assign o_mem_ready = (state == RUN);
    assign o_halted    = (state == HALT);

endmodule

// File: doc/wb_commit_stage.md
Name: wb_commit_stage

Overview:
- Write-back stage of the 5-stage pipeline. Sits between the MEM stage and both the register file write port and the difftest commit unit.
- Registers one retiring instruction per cycle and produces the register-file write.
- Generates the commit-valid and skip qualifiers consumed by difftest.
- Tracks the retired-instruction count and halts the pipeline after the simulation trap instruction (opcode 7'h6b).

Parameters:
- MMIO_TOP, 64'h0000_0000_8000_0000, load/store addresses strictly below this are MMIO and their commits are skipped
- TRAP_OPCODE, 7'h6b, opcode of the simulation-trap instruction

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low
- i_mem_valid  input  1  MEM stage presents an instruction
- o_mem_ready  output  1  stage can accept an instruction
- i_pc  input  64  PC of the presented instruction
- i_inst  input  32  instruction word
- i_rd  input  5  destination register index
- i_rd_wen  input  1  instruction writes rd
- i_rd_wdata  input  64  result to write
- i_mem_access  input  1  instruction is a load or store
- i_mem_addr  input  64  effective address, valid when i_mem_access=1
- i_intrNo  input  32  nonzero means an interrupt was taken on this slot
- o_rd  output  5  regfile write index
- o_rd_wen  output  1  regfile write enable
- o_rd_wdata  output  64  regfile write data
- o_pc  output  64  registered PC
- o_inst  output  32  registered instruction
- o_cmtvalid  output  1  one-cycle pulse per retired instruction
- o_skipcmt  output  1  difftest must skip comparison for this commit
- o_intrNo  output  32  registered interrupt number
- o_halted  output  1  trap retired, pipeline frozen
- o_instret  output  64  count of retired instructions

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs and registers go to 0, including o_halted and o_instret.
  - State goes to RUN.
  - Reset has priority over everything and aborts any in-flight slot; no commit is emitted in that cycle.
- FSM has 2 states:
  - RUN: o_mem_ready=1.
  - HALT: o_mem_ready=0 and o_halted=1. HALT is left only by reset.
- Accept happens when i_mem_valid & o_mem_ready at a clk edge.
  - On the next cycle, o_pc, o_inst, o_rd and o_rd_wdata hold the captured values.
  - Latency from accept to outputs is exactly 1 cycle.
  - Back-to-back accepts produce back-to-back commits.
- No accept this edge (bubble): the next cycle has o_cmtvalid=0, o_rd_wen=0, o_skipcmt=0 and o_intrNo=0. Data outputs hold their previous values.
- Normal retire (i_intrNo==0):
  - o_cmtvalid=1.
  - o_rd_wen = i_rd_wen & (i_rd != 0). A write to x0 is never issued, but it still commits.
- Interrupt slot (i_intrNo!=0):
  - o_cmtvalid=0, o_rd_wen=0, o_skipcmt=0.
  - o_intrNo = i_intrNo for exactly one cycle; o_pc = i_pc.
  - o_instret does not increment.
- Skip rule (evaluated at accept, registered): o_skipcmt=1 iff the slot is a normal retire and either condition holds:
  - i_mem_access & (i_mem_addr < MMIO_TOP), unsigned compare.
  - A CSR-read instruction: opcode 7'h73, funct3 != 0, and csr addr inst[31:20] is one of 12'hB00 (mcycle), 12'hC00 (cycle) or 12'h344 (mip).
- o_instret:
  - Increments by 1 in the cycle o_cmtvalid=1, i.e. it reflects the commit in the same cycle it appears.
  - Wraps modulo 2^64.
- Trap handling:
  - An accepted normal retire with i_inst[6:0]==TRAP_OPCODE commits normally with o_cmtvalid=1 and is counted.
  - The FSM enters HALT at the same edge the trap's outputs appear.
  - From the following cycle, no further accepts occur; o_cmtvalid and o_rd_wen stay 0.
- An interrupt slot carrying a trap opcode does not halt.
- i_mem_valid asserted while in HALT is ignored; nothing is latched.

Test Plan:
1. Reset then single retire: rst low 2 cycles, then accept pc=0x80000000, inst=0x00a00513 (addi a0,x0,10), rd=10, wdata=10. Next cycle requires o_cmtvalid=1, o_rd_wen=1, o_rd=10, o_rd_wdata=10, o_skipcmt=0, o_instret=1.
2. x0 and bubble: accept rd=0 with wen=1, then hold i_mem_valid=0 for 1 cycle. Requires o_rd_wen=0 and o_cmtvalid=1, then a cycle with o_cmtvalid=0. o_instret goes 1→2 and stays 2.
3. Skip rules:
   - Load with i_mem_addr=0x0200BFF8 gives o_skipcmt=1.
   - Load with addr=0x80001000 gives 0.
   - csrr with inst=0xB0002573 (csrrs a0,mcycle,x0) gives o_skipcmt=1.
   - csrr of mstatus (0x30002573) gives 0.
4. Interrupt slot: accept with i_intrNo=7, pc=0x80000100, rd_wen=1. Requires o_intrNo=7 for one cycle, o_pc=0x80000100, o_cmtvalid=0, o_rd_wen=0, o_instret unchanged. The following cycle has o_intrNo=0.
5. Trap: accept inst=0x0000006b, then keep i_mem_valid=1 for 5 cycles. Requires exactly one commit with o_cmtvalid=1. o_halted=1 and o_mem_ready=0 from that cycle on, with no further commits. rst low for 1 cycle returns o_halted=0, o_mem_ready=1, o_instret=0.
6. Reset mid-stream: accept continuously, assert rst=0 on the edge of an accept. Requires no commit pulse in the next cycle and all outputs 0.
